nib_in_byte_assembler: RTL and testbench
========================================

NIB_IN_BYTE_ASSEMBLER -- requirements
Module: nib_in_byte_assembler

Interface
REQ-001 Parameter: FIFO_AW, 2, address width; FIFO depth = 2**FIFO_AW bytes.
REQ-002 Port: clk  input  1  single system clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: select  input  1  transfer frame enable; low = idle, nibble phase cleared.
REQ-005 Port: nstrobe  input  1  nibble strobe from the external (Pi-side) sender; rising edge marks valid nin.
REQ-006 Port: nin  input  4  incoming nibble, MSB-first order (high nibble then low nibble).
REQ-007 Port: rd_en  input  1  consumer pop of the FIFO head.
REQ-008 Port: clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-009 Port: dout  output  8  FIFO head byte (first-word fall-through); 8'h00 when empty.
REQ-010 Port: empty  output  1  FIFO holds zero bytes.
REQ-011 Port: full  output  1  FIFO holds 2**FIFO_AW bytes.
REQ-012 Port: overrun  output  1  sticky: a completed byte was dropped because the FIFO was full.
REQ-013 Port: nib_phase  output  1  0 = expecting high nibble, 1 = expecting low nibble.

Function
REQ-014 Strobe rising edge is detected on the synchronized strobe using a previous-sample register; one capture per edge, regardless of strobe high duration.
REQ-015 nin is sampled through the same pipeline stages as nstrobe so data and edge are cycle-aligned.
REQ-016 Capture only when synchronized select = 1; edges while select = 0 are ignored.
REQ-017 Phase 0 capture: nin -> hold[7:4], nib_phase -> 1.
REQ-018 Phase 1 capture: {hold[7:4], nin} forms the byte, nib_phase -> 0, push request issued in the same cycle.
REQ-019 Push with FIFO not full, or full with rd_en same cycle: byte written at tail; count = count + 1 - pop.
REQ-020 Push with FIFO full and rd_en = 0: byte discarded, FIFO unchanged, overrun set to 1 next cycle.
REQ-021 overrun remains 1 until clr_ovr = 1 or reset; if clr_ovr and a new overrun coincide, overrun = 1.
REQ-022 rd_en with empty = 1 is ignored; pointers and count unchanged.
REQ-023 Pointers wrap modulo 2**FIFO_AW; count is FIFO_AW+1 bits; full = (count == depth), empty = (count == 0).
REQ-024 Synchronized select falling: nib_phase -> 0 and hold is discarded the next cycle; FIFO contents and overrun are retained.
REQ-025 A strobe edge detected in the same cycle that synchronized select falls is ignored.
REQ-026 Latency with NIB_IN_SYNC_EN: byte visible on dout/empty 4 clk after the second nstrobe rising edge at the pin (2 sync + edge + write); without it, 2 clk.

Reset
REQ-027 While reset = 1: pointers, count, nib_phase, hold, overrun and all synchronizer/edge registers = 0; dout = 8'h00, empty = 1, full = 0.
REQ-028 Reset asserted mid-byte discards the partial nibble; reset mid-frame requires the sender to restart with a high nibble.
REQ-029 After release, no spurious capture occurs if nstrobe is already high (edge register cleared to 0 and the first sample only sets it... i.e. edge register loads the synchronized level with capture suppressed for one cycle).

Configuration
REQ-030 Macro NIB_IN_SYNC_EN defined: nstrobe, select and nin each pass through a two-flop synchronizer before edge detection.
REQ-031 Macro NIB_IN_SYNC_EN undefined: inputs are treated as synchronous to clk; one register stage only (edge detect), latency per REQ-026.

Structure
REQ-032 Shared package nib_in_pkg holds: NIB_W = 4, BYTE_W = 8, default FIFO_AW, nibble and byte typedefs.
REQ-033 One sub-module nib_sync2 (two-flop synchronizer, width parameter, async reset to 0), instantiated only under NIB_IN_SYNC_EN.
REQ-034 FIFO storage is a register array inside the block; no separate FIFO module.

Verification
REQ-035 select = 1, strobes nin = 4'hA then 4'h5 -> dout = 8'hA5, empty 1->0 at REQ-026 latency, nib_phase back to 0.
REQ-036 Five bytes 8'h01..8'h05 pushed with no rd_en, FIFO_AW = 2 -> full = 1 after 4th, 5th dropped, overrun = 1; pops return 01,02,03,04 in order.
REQ-037 Full FIFO, final nibble capture coincident with rd_en -> count stays 4, no overrun, new byte at tail.
REQ-038 One nibble 4'h3, select dropped, then select = 1 with nibbles 4'hC, 4'h7 -> dout = 8'hC7 (not 8'h3C).
REQ-039 Reset asserted after high nibble, nstrobe held high across release -> no capture, empty = 1, nib_phase = 0.
REQ-040 overrun = 1, clr_ovr pulsed 1 cycle with no new drop -> overrun = 0 next cycle; FIFO contents unchanged.

Source files
------------

// File: rtl/nib_in_pkg.sv
// Shared widths, defaults and payload types for the nibble-to-byte input path.
package nib_in_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned FIFO_AW_DEF = 2;

    typedef logic [NIB_W-1:0]  nibble_t;
    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/nib_sync2.sv
// Two-flop synchronizer, async reset to 0. Only built when NIB_IN_SYNC_EN is defined.
`ifdef NIB_IN_SYNC_EN
module nib_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff1_q, ff1_d;
    logic [W-1:0] ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule
`endif

// File: rtl/nib_in_byte_assembler.sv
// Assembles MSB-first nibble pairs into bytes and queues them in a small FWFT FIFO.
// Define NIB_IN_SYNC_EN to put a two-flop synchronizer on select/nstrobe/nin.
module nib_in_byte_assembler
    import nib_in_pkg::*;
#(
    parameter int unsigned FIFO_AW = FIFO_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              select,
    input  logic              nstrobe,
    input  logic [NIB_W-1:0]  nin,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              nib_phase
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned ARM_W = 3;
`ifdef NIB_IN_SYNC_EN
    localparam int unsigned ARM_CYC = 4;
`else
    localparam int unsigned ARM_CYC = 2;
`endif

    logic    s_sel, s_strb;
    nibble_t s_nin;

`ifdef NIB_IN_SYNC_EN
    nib_sync2 #(.W(NIB_W + 2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({select, nstrobe, nin}),
        .q     ({s_sel, s_strb, s_nin})
    );
`else
    always_comb begin
        s_sel  = select;
        s_strb = nstrobe;
        s_nin  = nin;
    end
`endif

    logic             sel_q, sel_d;
    logic             strb_q, strb_d;
    logic             strb_prev_q, strb_prev_d;
    nibble_t          nin_q, nin_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic             phase_q, phase_d;
    nibble_t          hold_q, hold_d;
    byte_t            mem_q [DEPTH];
    byte_t            mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovr_q, ovr_d;

    logic armed, strb_rise, capture, push, pop, wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Edge detect is held off until the post-reset level has reached the previous-sample register.
    always_comb begin
        sel_d       = s_sel;
        strb_d      = s_strb;
        nin_d       = s_nin;
        strb_prev_d = strb_q;
        arm_cnt_d   = arm_cnt_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovr_d       = ovr_q;

        armed     = (arm_cnt_q == ARM_W'(ARM_CYC));
        strb_rise = armed & strb_q & ~strb_prev_q;
        capture   = strb_rise & sel_q;
        push      = capture & phase_q;
        pop       = rd_en & ~empty;
        wr        = push & (~full | pop);

        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        if (!sel_q) begin
            phase_d = 1'b0;
            hold_d  = '0;
        end else if (capture) begin
            phase_d = ~phase_q;
            hold_d  = phase_q ? nibble_t'(0) : nin_q;
        end

        if (wr) begin
            mem_d[wr_ptr_q] = {hold_q, nin_q};
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        count_d = count_q + CW'(wr) - CW'(pop);

        // A fresh drop wins over a coincident clear.
        if (push && full && !pop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= 1'b0;
            strb_q      <= 1'b0;
            strb_prev_q <= 1'b0;
            nin_q       <= '0;
            arm_cnt_q   <= '0;
            phase_q     <= 1'b0;
            hold_q      <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovr_q       <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            strb_q      <= strb_d;
            strb_prev_q <= strb_prev_d;
            nin_q       <= nin_d;
            arm_cnt_q   <= arm_cnt_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovr_q       <= ovr_d;
        end
    end

    assign dout      = empty ? byte_t'(0) : mem_q[rd_ptr_q];
    assign overrun   = ovr_q;
    assign nib_phase = phase_q;

endmodule

// File: tb/tb_nib_in_byte_assembler.sv
// Directed + random bench for nib_in_byte_assembler against a queue-based byte model.
module tb_nib_in_byte_assembler;

`ifdef NIB_IN_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int SETTLE = LAT + 3;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset, select, nstrobe, rd_en, clr_ovr;
    logic [3:0] nin;
    logic [7:0] dout;
    logic       empty, full, overrun, nib_phase;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_m[$];
    logic       ph_m, ovr_m, sel_m;
    logic [3:0] hold_m;

    nib_in_byte_assembler #(.FIFO_AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .select    (select),
        .nstrobe   (nstrobe),
        .nin       (nin),
        .rd_en     (rd_en),
        .clr_ovr   (clr_ovr),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun),
        .nib_phase (nib_phase)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_d;
        exp_d = (q_m.size() != 0) ? q_m[0] : 8'h00;
        chk({tag, ".dout"},    dout,                  exp_d);
        chk({tag, ".empty"},   {7'd0, empty},         {7'd0, q_m.size() == 0});
        chk({tag, ".full"},    {7'd0, full},          {7'd0, q_m.size() == DEPTH});
        chk({tag, ".overrun"}, {7'd0, overrun},       {7'd0, ovr_m});
        chk({tag, ".phase"},   {7'd0, nib_phase},     {7'd0, ph_m});
    endtask

    task automatic model_reset();
        q_m.delete();
        ph_m   = 1'b0;
        ovr_m  = 1'b0;
        hold_m = 4'h0;
    endtask

    task automatic set_sel(input logic v);
        select = v;
        tick(SETTLE);
        sel_m = v;
        if (!v) ph_m = 1'b0;
    endtask

    // One strobe pulse; optional rd_en pulse timed to coincide with the resulting capture.
    task automatic send_nib(input logic [3:0] v, input int pop_at);
        logic popped;
        popped  = 1'b0;
        nin     = v;
        nstrobe = 1'b1;
        for (int k = 1; k <= SETTLE; k++) begin
            tick(1);
            if (k == pop_at && q_m.size() != 0) begin
                chk("pop_head", dout, q_m[0]);
                popped = 1'b1;
            end
            rd_en = (k == pop_at);
        end
        nstrobe = 1'b0;
        tick(SETTLE);
        if (popped) void'(q_m.pop_front());
        if (sel_m) begin
            if (!ph_m) begin
                hold_m = v;
                ph_m   = 1'b1;
            end else begin
                ph_m = 1'b0;
                if (q_m.size() < DEPTH) q_m.push_back({hold_m, v});
                else                    ovr_m = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int pop_at);
        send_nib(b[7:4], -1);
        send_nib(b[3:0], pop_at);
    endtask

    task automatic pop_chk(input string tag);
        chk(tag, dout, (q_m.size() != 0) ? q_m[0] : 8'h00);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
        if (q_m.size() != 0) void'(q_m.pop_front());
    endtask

    initial begin
        reset = 1'b1; select = 1'b0; nstrobe = 1'b0; nin = 4'h0;
        rd_en = 1'b0; clr_ovr = 1'b0; sel_m = 1'b0;
        model_reset();
        tick(3);
        check_all("reset");
        reset = 1'b0;
        tick(2);

        // Captures ignored while idle
        send_byte(8'hFF, -1);
        check_all("idle");

        // A5 with exact latency measured from the second strobe edge
        set_sel(1'b1);
        send_nib(4'hA, -1);
        check_all("hi_nib");
        nin = 4'h5;
        nstrobe = 1'b1;
        tick(LAT - 1);
        chk("lat_empty_before", {7'd0, empty}, 8'd1);
        tick(1);
        chk("lat_empty_after", {7'd0, empty}, 8'd0);
        chk("lat_dout", dout, 8'hA5);
        nstrobe = 1'b0;
        tick(SETTLE);
        q_m.push_back(8'hA5);
        ph_m = 1'b0;
        check_all("a5");
        pop_chk("pop_a5");
        check_all("a5_drained");

        // Fill, overflow, clear overrun
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), -1);
            if (i == 4) chk("full_after4", {7'd0, full}, 8'd1);
        end
        check_all("overflow");
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        ovr_m   = 1'b0;
        tick(1);
        check_all("clr_ovr");

        // Full FIFO, final capture coincident with rd_en
        send_byte(8'h66, LAT - 1);
        check_all("push_pop_full");
        for (int i = 0; i < 4; i++) pop_chk("drain");
        check_all("drained");

        // Orphan high nibble discarded by select drop
        send_nib(4'h3, -1);
        check_all("orphan");
        set_sel(1'b0);
        check_all("sel_drop");
        set_sel(1'b1);
        send_byte(8'hC7, -1);
        chk("c7", dout, 8'hC7);
        check_all("c7_all");
        pop_chk("pop_c7");

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_byte(b, ($urandom_range(0, 3) == 0) ? LAT - 1 : -1);
            if ($urandom_range(0, 2) != 0) pop_chk("rnd_pop");
            if ($urandom_range(0, 4) == 0) begin
                clr_ovr = 1'b1;
                tick(1);
                clr_ovr = 1'b0;
                ovr_m   = 1'b0;
                tick(1);
            end
            check_all("rnd");
        end

        // Reset mid-byte with strobe held high across release
        send_nib(4'h3, -1);
        reset   = 1'b1;
        nstrobe = 1'b1;
        nin     = 4'h9;
        model_reset();
        tick(2);
        check_all("rst_mid");
        reset = 1'b0;
        tick(SETTLE + 2);
        check_all("rst_release");
        nstrobe = 1'b0;
        tick(SETTLE);
        send_byte(8'h5A, -1);
        check_all("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
